// File: rtl/falc_dma_pkg.sv
// rtl/falc_dma_pkg.sv - shared FSM codes, command/status bit positions and direction constants
package falc_dma_pkg;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_REQ   = 4'd1;
    localparam logic [3:0] S_ACQ   = 4'd2;
    localparam logic [3:0] S_RAMRD = 4'd3;
    localparam logic [3:0] S_BYTE  = 4'd4;
    localparam logic [3:0] S_RAMWR = 4'd5;
    localparam logic [3:0] S_REL   = 4'd6;
    localparam logic [3:0] S_REL2  = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    localparam int CMD_START    = 0;
    localparam int CMD_ABORT    = 1;
    localparam int CMD_INT_CLR  = 2;
    localparam int CMD_ADDR_INC = 3;

    localparam int ST_BUSY   = 4;
    localparam int ST_DONE   = 5;
    localparam int ST_ABORT  = 6;
    localparam int ST_GNT_TO = 7;

    localparam logic DIR_F2H = 1'b0;
    localparam logic DIR_H2F = 1'b1;

endpackage

// File: rtl/falc_mux_bus_cycle.sv
// rtl/falc_mux_bus_cycle.sv - one ALE/STB/HOLD byte cycle on the multiplexed framer bus
module falc_mux_bus_cycle #(
    parameter int ALE_CYC  = 2,
    parameter int STB_CYC  = 4,
    parameter int HOLD_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] badd_i,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ale,
    output logic       rd_n,
    output logic       wr_n,
    output logic       cs_act,
    output logic       badd_oe,
    output logic [7:0] badd_o
);

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_ALE  = 2'd1;
    localparam logic [1:0] PH_STB  = 2'd2;
    localparam logic [1:0] PH_HOLD = 2'd3;

    logic [1:0] ph;
    logic [7:0] cnt;
    logic       ph_end;

    always_comb begin
        ph_end = 1'b0;
        case (ph)
            PH_ALE:  ph_end = (cnt == 8'(ALE_CYC - 1));
            PH_STB:  ph_end = (cnt == 8'(STB_CYC - 1));
            PH_HOLD: ph_end = (cnt == 8'(HOLD_CYC - 1));
            default: ph_end = 1'b0;
        endcase
    end

    assign done = (ph == PH_HOLD) && ph_end;

    // A start in the last HOLD cycle chains straight into the next ALE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph    <= PH_IDLE;
            cnt   <= 8'd0;
            rdata <= 8'd0;
        end else if (start) begin
            ph  <= PH_ALE;
            cnt <= 8'd0;
        end else if (ph != PH_IDLE) begin
            if (ph_end) begin
                cnt <= 8'd0;
                ph  <= (ph == PH_HOLD) ? PH_IDLE : ph + 2'd1;
                if (ph == PH_STB && !wr)
                    rdata <= badd_i;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign ale     = (ph == PH_ALE);
    assign rd_n    = !(ph == PH_STB && !wr);
    assign wr_n    = !(ph == PH_STB && wr);
    assign cs_act  = (ph != PH_IDLE);
    assign badd_oe = (ph == PH_ALE) || (ph == PH_STB && wr);
    assign badd_o  = (ph == PH_ALE) ? addr : ((ph == PH_STB && wr) ? wdata : 8'd0);

endmodule

// File: rtl/falc_mux_dma_engine.sv
// rtl/falc_mux_dma_engine.sv - multi-channel framer<->HPRAM DMA master on the muxed 8-bit bus
// Optional grant timeout: FALC_DMA_GNT_TIMEOUT_EN
module falc_mux_dma_engine #(
    parameter int CS_NUM   = 2,
    parameter int CS_W     = (CS_NUM > 1) ? $clog2(CS_NUM) : 1,
    parameter int ADDR_W   = 13,
    parameter int RAM_AW   = 12,
    parameter int LEN_W    = 10,
    parameter int ALE_CYC  = 2,
    parameter int STB_CYC  = 4,
    parameter int HOLD_CYC = 1,
    parameter int GNT_TO   = 255
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [7:0]        F56_BADD_I,
    output logic [7:0]        F56_BADD_O,
    output logic              F56_BADD_OE_O,
    output logic              F56_ALE_O,
    output logic              F56_RDn_O,
    output logic              F56_WRn_O,
    output logic [CS_NUM-1:0] F56_CSn_O,
    input  logic [31:0]       HPRAM_DATA_I,
    output logic [31:0]       HPRAM_DATA_O,
    output logic [RAM_AW-1:0] HPRAM_ADD_O,
    output logic              HPRAM_WEN_O,
    output logic              HPRAM_REN_O,
    output logic              DMA_BUS_REQ_O,
    input  logic              DMA_BUS_GNT_I,
    output logic              DMA_OUTPUT_EN_O,
    input  logic [ADDR_W-1:0] DMA_SRC_ADD_I,
    input  logic [ADDR_W-1:0] DMA_DST_ADD_I,
    input  logic [LEN_W-1:0]  DMA_LEN_I,
    input  logic [CS_W-1:0]   DMA_CS_SEL_I,
    input  logic              DMA_DATA_DIR_I,
    input  logic [7:0]        DMA_CMD_I,
    output logic [7:0]        DMA_STATE_O,
    output logic              DMA_INT_REQ_O
);
    import falc_dma_pkg::*;

    logic [3:0]        state, state_d;
    logic [2:0]        cmd_q;
    logic              start_q, abort_q, clr_q, accept;
    logic              dir, inc, abort_pend, last;
    logic [CS_W-1:0]   sel;
    logic [LEN_W-1:0]  rem;
    logic [7:0]        fadr, byte_out, bus_rdata;
    logic [RAM_AW-1:0] radr;
    logic [1:0]        lane;
    logic [31:0]       word;
    logic              rd_lat, st_done, st_abort, st_to, int_q, to_hit, abort_ev;
    logic              bus_start, bus_done, cs_act;
    logic              unused_inputs;

    assign unused_inputs = ^{DMA_SRC_ADD_I, DMA_DST_ADD_I, DMA_CMD_I[7:4]};

    assign accept   = (state == S_IDLE) && start_q && !abort_q;
    assign last     = (rem == LEN_W'(1));
    assign abort_ev = (state == S_REL2) && (rem != '0) && abort_pend;
    assign byte_out = word[{lane, 3'b000} +: 8];

    // Byte boundaries are the only points where grant loss or abort are honoured
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (accept) state_d = (DMA_LEN_I == '0) ? S_DONE : S_REQ;
            S_REQ:   if (abort_pend) state_d = S_REL;
                     else if (DMA_BUS_GNT_I) state_d = S_ACQ;
                     else if (to_hit) state_d = S_IDLE;
            S_ACQ:   state_d = (dir == DIR_H2F && lane == 2'd0) ? S_RAMRD : S_BYTE;
            S_RAMRD: state_d = S_BYTE;
            S_BYTE:  if (bus_done) begin
                         if (dir == DIR_F2H && (lane == 2'd3 || last)) state_d = S_RAMWR;
                         else if (last || abort_pend || !DMA_BUS_GNT_I) state_d = S_REL;
                         else if (dir == DIR_H2F && lane == 2'd3) state_d = S_RAMRD;
                     end
            S_RAMWR: state_d = (rem == '0 || abort_pend || !DMA_BUS_GNT_I) ? S_REL : S_BYTE;
            S_REL:   state_d = S_REL2;
            S_REL2:  state_d = (rem == '0) ? S_DONE : (abort_pend ? S_IDLE : S_REQ);
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus_start = (state_d == S_BYTE) && (state != S_BYTE || bus_done);

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state <= S_IDLE;
            cmd_q <= 3'd0; start_q <= 1'b0; abort_q <= 1'b0; clr_q <= 1'b0;
            dir <= 1'b0; inc <= 1'b0; sel <= '0; rem <= '0;
            fadr <= 8'd0; radr <= '0; lane <= 2'd0; word <= 32'd0;
            rd_lat <= 1'b0; abort_pend <= 1'b0;
            st_done <= 1'b0; st_abort <= 1'b0; int_q <= 1'b0;
        end else begin
            state   <= state_d;
            cmd_q   <= DMA_CMD_I[2:0];
            start_q <= DMA_CMD_I[CMD_START]   & ~cmd_q[CMD_START];
            abort_q <= DMA_CMD_I[CMD_ABORT]   & ~cmd_q[CMD_ABORT];
            clr_q   <= DMA_CMD_I[CMD_INT_CLR] & ~cmd_q[CMD_INT_CLR];
            rd_lat  <= (state == S_RAMRD);
            if (rd_lat)
                word <= HPRAM_DATA_I;
            if (abort_q && state != S_IDLE)
                abort_pend <= 1'b1;
            if (accept) begin
                dir  <= DMA_DATA_DIR_I;
                inc  <= DMA_CMD_I[CMD_ADDR_INC];
                sel  <= DMA_CS_SEL_I;
                rem  <= DMA_LEN_I;
                fadr <= DMA_DATA_DIR_I ? DMA_DST_ADD_I[7:0] : DMA_SRC_ADD_I[7:0];
                radr <= DMA_DATA_DIR_I ? DMA_SRC_ADD_I[RAM_AW-1:0] : DMA_DST_ADD_I[RAM_AW-1:0];
                lane <= 2'd0;
                word <= 32'd0;
                abort_pend <= 1'b0;
                st_done    <= 1'b0;
                st_abort   <= 1'b0;
            end
            if (state == S_BYTE && bus_done) begin
                rem  <= rem - LEN_W'(1);
                lane <= lane + 2'd1;
                if (inc)
                    fadr <= fadr + 8'd1;
                if (dir == DIR_F2H)
                    word[{lane, 3'b000} +: 8] <= bus_rdata;
            end
            if (state == S_RAMRD)
                radr <= radr + RAM_AW'(1);
            if (state == S_RAMWR) begin
                radr <= radr + RAM_AW'(1);
                word <= 32'd0;
            end
            if (state == S_DONE)
                st_done <= 1'b1;
            if (abort_ev)
                st_abort <= 1'b1;
            if (state == S_DONE || abort_ev || to_hit)
                int_q <= 1'b1;
            else if (clr_q)
                int_q <= 1'b0;
        end
    end

`ifdef FALC_DMA_GNT_TIMEOUT_EN
    logic [15:0] to_cnt;

    assign to_hit = (state == S_REQ) && !abort_pend && !DMA_BUS_GNT_I && (to_cnt == 16'(GNT_TO - 1));

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            to_cnt <= 16'd0;
            st_to  <= 1'b0;
        end else begin
            to_cnt <= (state == S_REQ) ? to_cnt + 16'd1 : 16'd0;
            if (accept)
                st_to <= 1'b0;
            else if (to_hit)
                st_to <= 1'b1;
        end
    end
`else
    localparam int unused_gnt_to = GNT_TO;
    assign to_hit = 1'b0;
    assign st_to  = 1'b0;
`endif

    falc_mux_bus_cycle #(
        .ALE_CYC (ALE_CYC),
        .STB_CYC (STB_CYC),
        .HOLD_CYC(HOLD_CYC)
    ) u_bus (
        .clk    (CLK_I),
        .rst    (RST_I),
        .start  (bus_start),
        .wr     (dir),
        .addr   (fadr),
        .wdata  (byte_out),
        .badd_i (F56_BADD_I),
        .done   (bus_done),
        .rdata  (bus_rdata),
        .ale    (F56_ALE_O),
        .rd_n   (F56_RDn_O),
        .wr_n   (F56_WRn_O),
        .cs_act (cs_act),
        .badd_oe(F56_BADD_OE_O),
        .badd_o (F56_BADD_O)
    );

    always_comb begin
        F56_CSn_O = '1;
        for (int i = 0; i < CS_NUM; i++)
            if (cs_act && sel == CS_W'(i))
                F56_CSn_O[i] = 1'b0;
    end

    assign HPRAM_REN_O     = (state == S_RAMRD);
    assign HPRAM_WEN_O     = (state == S_RAMWR);
    assign HPRAM_ADD_O     = (HPRAM_REN_O || HPRAM_WEN_O) ? radr : '0;
    assign HPRAM_DATA_O    = HPRAM_WEN_O ? word : 32'd0;
    assign DMA_OUTPUT_EN_O = state inside {S_ACQ, S_RAMRD, S_BYTE, S_RAMWR};
    assign DMA_BUS_REQ_O   = state inside {S_REQ, S_ACQ, S_RAMRD, S_BYTE, S_RAMWR, S_REL};
    assign DMA_STATE_O     = {st_to, st_abort, st_done, state != S_IDLE, state};
    assign DMA_INT_REQ_O   = int_q;

endmodule

// File: tb/tb_falc_mux_dma_engine.sv
// tb/tb_falc_mux_dma_engine.sv - directed self-checking bench for falc_mux_dma_engine
module tb_falc_mux_dma_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  badd_i, badd_o;
    logic        badd_oe, ale, rdn, wrn;
    logic [1:0]  csn;
    logic [31:0] hp_rdata = 32'd0;
    logic [31:0] hp_wdata;
    logic [11:0] hp_add;
    logic        hp_wen, hp_ren;
    logic        req, gnt = 1'b1, oe;
    logic [12:0] src = 13'd0, dst = 13'd0;
    logic [9:0]  len = 10'd0;
    logic        sel = 1'b0, dir = 1'b0;
    logic [7:0]  cmd = 8'd0;
    logic [7:0]  dma_state;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [7:0]  fmem [0:255];
    logic [31:0] hmem [0:4095];
    logic [7:0]  addr_l = 8'd0;

    int rd_n, wr_n, wen_n, ren_n, req_rise, req_hi, wr_cur;
    logic [7:0]  rd_addr [0:31];
    logic [1:0]  rd_cs   [0:31];
    logic [7:0]  wr_addr [0:31];
    logic [7:0]  wr_data [0:31];
    logic [1:0]  wr_cs   [0:31];
    int          wr_len  [0:31];
    logic [11:0] wen_addr [0:31];
    logic [31:0] wen_data [0:31];
    logic [11:0] ren_addr [0:31];
    logic rdn_prev = 1'b1, wrn_prev = 1'b1, req_prev = 1'b0;

    always #5 clk = ~clk;

    assign badd_i = fmem[addr_l];

    falc_mux_dma_engine dut (
        .CLK_I(clk), .RST_I(rst),
        .F56_BADD_I(badd_i), .F56_BADD_O(badd_o), .F56_BADD_OE_O(badd_oe),
        .F56_ALE_O(ale), .F56_RDn_O(rdn), .F56_WRn_O(wrn), .F56_CSn_O(csn),
        .HPRAM_DATA_I(hp_rdata), .HPRAM_DATA_O(hp_wdata), .HPRAM_ADD_O(hp_add),
        .HPRAM_WEN_O(hp_wen), .HPRAM_REN_O(hp_ren),
        .DMA_BUS_REQ_O(req), .DMA_BUS_GNT_I(gnt), .DMA_OUTPUT_EN_O(oe),
        .DMA_SRC_ADD_I(src), .DMA_DST_ADD_I(dst), .DMA_LEN_I(len),
        .DMA_CS_SEL_I(sel), .DMA_DATA_DIR_I(dir), .DMA_CMD_I(cmd),
        .DMA_STATE_O(dma_state), .DMA_INT_REQ_O(irq)
    );

    always @(posedge clk)
        if (hp_ren) hp_rdata <= hmem[hp_add];

    always @(negedge clk) begin
        if (ale) addr_l = badd_o;
        if (!rdn && rdn_prev && rd_n < 32) begin
            rd_addr[rd_n] = addr_l; rd_cs[rd_n] = csn; rd_n++;
        end
        if (!wrn && wrn_prev && wr_n < 32) begin
            wr_addr[wr_n] = addr_l; wr_data[wr_n] = badd_o; wr_cs[wr_n] = csn; wr_n++; wr_cur = 1;
        end else if (!wrn) wr_cur++;
        if (wrn && !wrn_prev && wr_n > 0) wr_len[wr_n-1] = wr_cur;
        if (hp_wen && wen_n < 32) begin wen_addr[wen_n] = hp_add; wen_data[wen_n] = hp_wdata; wen_n++; end
        if (hp_ren && ren_n < 32) begin ren_addr[ren_n] = hp_add; ren_n++; end
        if (req && !req_prev) req_rise++;
        if (req) req_hi++;
        rdn_prev = rdn; wrn_prev = wrn; req_prev = req;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        rd_n = 0; wr_n = 0; wen_n = 0; ren_n = 0; req_rise = 0; req_hi = 0; wr_cur = 0;
    endtask

    task automatic pulse_cmd(input logic [7:0] c);
        cmd = c; cyc(2); cmd = 8'd0; cyc(2);
    endtask

    task automatic start_xfer(input logic [12:0] s, input logic [12:0] d, input logic [9:0] l,
                              input logic cs, input logic dr, input logic inc);
        src = s; dst = d; len = l; sel = cs; dir = dr;
        cmd = {4'd0, inc, 3'b001};
        cyc(3);
        cmd = 8'd0;
    endtask

    task automatic wait_end(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            if (dma_state[5] || dma_state[6] || dma_state[7]) ok = 1'b1;
            else cyc(1);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (dma_state !== 8'h00 || req !== 1'b0 || oe !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL reset_status state=%h req=%b oe=%b int=%b required 00/0/0/0", dma_state, req, oe, irq);
        end
        checks++;
        if (csn !== 2'b11 || rdn !== 1'b1 || wrn !== 1'b1 || ale !== 1'b0 || badd_oe !== 1'b0 || badd_o !== 8'h00) begin
            errors++; $display("FAIL reset_bus csn=%b rdn=%b wrn=%b ale=%b oe=%b badd=%h", csn, rdn, wrn, ale, badd_oe, badd_o);
        end
        checks++;
        if (hp_wen !== 1'b0 || hp_ren !== 1'b0 || hp_add !== 12'h000 || hp_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_hpram wen=%b ren=%b add=%h data=%h required zeros", hp_wen, hp_ren, hp_add, hp_wdata);
        end
    endtask

    task automatic test_read_f2h();
        bit ok;
        gnt = 1'b1; clear_log();
        start_xfer(13'h010, 13'h020, 10'd6, 1'b1, 1'b0, 1'b1);
        wait_end(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL read_timeout no completion status=%h", dma_state); end
        checks++;
        if (rd_n !== 6) begin errors++; $display("FAIL read_count got %0d required 6", rd_n); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rd_addr[i] !== 8'(8'h10 + i) || rd_cs[i] !== 2'b01) begin
                errors++; $display("FAIL read_addr[%0d] got %h cs %b required %h cs 01", i, rd_addr[i], rd_cs[i], 8'(8'h10 + i));
            end
        end
        checks++;
        if (wen_n !== 2) begin errors++; $display("FAIL read_wen_count got %0d required 2", wen_n); end
        checks++;
        if (wen_addr[0] !== 12'h020 || wen_data[0] !== 32'h43424140) begin
            errors++; $display("FAIL read_word0 got %h@%h required 43424140@020", wen_data[0], wen_addr[0]);
        end
        checks++;
        if (wen_addr[1] !== 12'h021 || wen_data[1] !== 32'h00004544) begin
            errors++; $display("FAIL read_word1 got %h@%h required 00004544@021", wen_data[1], wen_addr[1]);
        end
        cyc(1);
        checks++;
        if (dma_state[6:4] !== 3'b010 || irq !== 1'b1 || req !== 1'b0) begin
            errors++; $display("FAIL read_status st=%h int=%b req=%b required done,int,req=0", dma_state, irq, req);
        end
    endtask

    task automatic test_int_clr();
        pulse_cmd(8'h04);
        checks++;
        if (irq !== 1'b0 || dma_state[5] !== 1'b1) begin
            errors++; $display("FAIL int_clr int=%b done=%b required 0 and 1", irq, dma_state[5]);
        end
    endtask

    task automatic test_write_h2f();
        bit ok;
        logic [7:0] exp_d [0:3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
        gnt = 1'b1; clear_log();
        start_xfer(13'h005, 13'h0A7, 10'd4, 1'b0, 1'b1, 1'b0);
        wait_end(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL write_timeout no completion status=%h", dma_state); end
        checks++;
        if (ren_n !== 1 || ren_addr[0] !== 12'h005) begin
            errors++; $display("FAIL write_ren got %0d reads first@%h required 1@005", ren_n, ren_addr[0]);
        end
        checks++;
        if (wr_n !== 4) begin errors++; $display("FAIL write_count got %0d required 4", wr_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_data[i] !== exp_d[i] || wr_addr[i] !== 8'hA7 || wr_len[i] !== 4 || wr_cs[i] !== 2'b10) begin
                errors++; $display("FAIL write_byte[%0d] got %h@%h len %0d cs %b required %h@a7 len 4 cs 10",
                                   i, wr_data[i], wr_addr[i], wr_len[i], wr_cs[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_gnt_loss();
        bit ok;
        int t;
        gnt = 1'b1; clear_log();
        pulse_cmd(8'h04);
        start_xfer(13'h040, 13'h030, 10'd8, 1'b0, 1'b0, 1'b1);
        t = 0;
        while (rd_n < 2 && t < 200) begin cyc(1); t++; end
        gnt = 1'b0;
        cyc(15);
        gnt = 1'b1;
        wait_end(400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL gnt_timeout no completion status=%h", dma_state); end
        checks++;
        if (req_rise !== 2) begin errors++; $display("FAIL gnt_req_rises got %0d required 2", req_rise); end
        checks++;
        if (rd_n !== 8) begin errors++; $display("FAIL gnt_read_count got %0d required 8", rd_n); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_addr[i] !== 8'(8'h40 + i)) begin
                errors++; $display("FAIL gnt_addr[%0d] got %h required %h", i, rd_addr[i], 8'(8'h40 + i));
            end
        end
        checks++;
        if (wen_n !== 2 || wen_data[0] !== 32'h73727170 || wen_data[1] !== 32'h77767574 || wen_addr[1] !== 12'h031) begin
            errors++; $display("FAIL gnt_words got %0d words %h %h@%h required 73727170 77767574@031",
                               wen_n, wen_data[0], wen_data[1], wen_addr[1]);
        end
    endtask

    task automatic test_abort();
        bit ok;
        int t;
        gnt = 1'b1; clear_log();
        pulse_cmd(8'h04);
        start_xfer(13'h080, 13'h100, 10'd8, 1'b1, 1'b0, 1'b1);
        t = 0;
        while (rd_n < 3 && t < 200) begin cyc(1); t++; end
        cmd = 8'h02; cyc(2); cmd = 8'h00;
        wait_end(300, ok);
        cyc(1);
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_timeout no completion status=%h", dma_state); end
        checks++;
        if (rd_n !== 3 || wen_n !== 0) begin
            errors++; $display("FAIL abort_traffic reads %0d wens %0d required 3 and 0", rd_n, wen_n);
        end
        checks++;
        if (dma_state[6:4] !== 3'b100 || irq !== 1'b1 || req !== 1'b0) begin
            errors++; $display("FAIL abort_status st=%h int=%b req=%b required aborted,int,req=0", dma_state, irq, req);
        end
    endtask

    task automatic test_len_zero();
        clear_log();
        pulse_cmd(8'h04);
        start_xfer(13'h001, 13'h002, 10'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dma_state[6:5] !== 2'b01 || irq !== 1'b1) begin
            errors++; $display("FAIL len0_done st=%h int=%b required done and int", dma_state, irq);
        end
        cyc(3);
        checks++;
        if (req_rise !== 0 || dma_state[4] !== 1'b0) begin
            errors++; $display("FAIL len0_no_req rises %0d busy %b required 0 and 0", req_rise, dma_state[4]);
        end
    endtask

    task automatic test_start_abort();
        clear_log();
        src = 13'h010; dst = 13'h020; len = 10'd4; dir = 1'b0;
        cmd = 8'h03; cyc(3); cmd = 8'h00; cyc(4);
        checks++;
        if (dma_state[4] !== 1'b0 || req_rise !== 0) begin
            errors++; $display("FAIL start_abort busy %b rises %0d required 0 and 0", dma_state[4], req_rise);
        end
    endtask

    task automatic test_gnt_timeout();
        bit ok;
        gnt = 1'b0; clear_log();
        pulse_cmd(8'h04);
        start_xfer(13'h010, 13'h020, 10'd4, 1'b0, 1'b0, 1'b1);
`ifdef FALC_DMA_GNT_TIMEOUT_EN
        wait_end(400, ok);
        cyc(1);
        checks++;
        if (!ok || req_hi !== 255) begin
            errors++; $display("FAIL gnt_to_len completed %b req high %0d required 255", ok, req_hi);
        end
        checks++;
        if (dma_state[7] !== 1'b1 || irq !== 1'b1 || req !== 1'b0) begin
            errors++; $display("FAIL gnt_to_status st=%h int=%b req=%b required bit7,int,req=0", dma_state, irq, req);
        end
`else
        cyc(300);
        checks++;
        if (req !== 1'b1 || dma_state[7] !== 1'b0 || dma_state[4] !== 1'b1) begin
            errors++; $display("FAIL gnt_wait req=%b st=%h required req=1 bit7=0 busy", req, dma_state);
        end
        pulse_cmd(8'h02);
        wait_end(50, ok);
        cyc(1);
        checks++;
        if (!ok || dma_state[6] !== 1'b1 || req !== 1'b0 || irq !== 1'b1) begin
            errors++; $display("FAIL gnt_wait_abort st=%h req=%b int=%b required aborted req=0 int=1", dma_state, req, irq);
        end
`endif
        gnt = 1'b1;
    endtask

    task automatic test_reset_mid();
        int t;
        gnt = 1'b1; clear_log();
        start_xfer(13'h060, 13'h040, 10'd4, 1'b0, 1'b0, 1'b1);
        t = 0;
        while (rdn !== 1'b0 && t < 200) begin cyc(1); t++; end
        checks++;
        if (rdn !== 1'b0) begin errors++; $display("FAIL rst_mid_setup rdn=%b required 0 before reset", rdn); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rdn !== 1'b1 || csn !== 2'b11 || req !== 1'b0 || oe !== 1'b0 || ale !== 1'b0 || badd_oe !== 1'b0) begin
            errors++; $display("FAIL rst_mid_bus rdn=%b csn=%b req=%b oe=%b ale=%b boe=%b", rdn, csn, req, oe, ale, badd_oe);
        end
        checks++;
        if (dma_state !== 8'h00 || irq !== 1'b0 || hp_wen !== 1'b0) begin
            errors++; $display("FAIL rst_mid_status st=%h int=%b wen=%b required 00/0/0", dma_state, irq, hp_wen);
        end
        cyc(2);
        rst = 1'b0;
        cyc(2);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) fmem[a] = 8'(a + 8'h30);
        for (int a = 0; a < 4096; a++) hmem[a] = 32'h0;
        hmem[5] = 32'h44332211;
        clear_log();
        cyc(3);
        rst = 1'b0;
        cyc(2);
        test_reset();
        test_read_f2h();
        test_int_clr();
        test_write_h2f();
        test_gnt_loss();
        test_abort();
        test_len_zero();
        test_start_abort();
        test_gnt_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/falc_mux_dma_engine.md
# falc_mux_dma_engine

Multi-channel successor to the FALC56 DMA engine: moves byte streams between FALC framers on the shared multiplexed 8-bit bus and the 32-bit HPRAM. It acts as bus master once granted by the board arbiter, packing framer bytes into HPRAM words on reads and unpacking them on writes. The chip-select count, timing and length width are parameters. The block sits between the PCI-side register file, which supplies commands, and the framer bus.

## Interface
- CS_NUM, 2: framer chip selects; CS_W = max(1, $clog2(CS_NUM))
- ADDR_W, 13: width of DMA_SRC/DST_ADD_I
- RAM_AW, 12: HPRAM word-address width, ≤ ADDR_W
- LEN_W, 10: transfer length width, in bytes
- ALE_CYC, 2 / STB_CYC, 4 / HOLD_CYC, 1: bus phase lengths in CLK_I cycles, each ≥ 1
- GNT_TO, 255: grant timeout in cycles, used only with the macro
- CLK_I  in  1  single clock
- RST_I  in  1  asynchronous, active-high reset
- F56_BADD_I / F56_BADD_O  in/out  8  multiplexed address/data bus
- F56_BADD_OE_O  out  1  bus drive enable
- F56_ALE_O, F56_RDn_O, F56_WRn_O  out  1  bus strobes
- F56_CSn_O  out  CS_NUM  active-low chip selects
- HPRAM_DATA_I / HPRAM_DATA_O  in/out  32  HPRAM data; read latency 1 cycle
- HPRAM_ADD_O  out  RAM_AW  HPRAM word address
- HPRAM_WEN_O, HPRAM_REN_O  out  1  single-cycle write and read strobes
- DMA_BUS_REQ_O  out  1  bus request
- DMA_BUS_GNT_I  in  1  bus grant
- DMA_OUTPUT_EN_O  out  1  enables the board bus buffers
- DMA_SRC_ADD_I, DMA_DST_ADD_I  in  ADDR_W  source and destination addresses
- DMA_LEN_I  in  LEN_W  byte count
- DMA_CS_SEL_I  in  CS_W  target framer
- DMA_DATA_DIR_I  in  1  0: framer→HPRAM, 1: HPRAM→framer
- DMA_CMD_I  in  8  command bits: [0] START, [1] ABORT, [2] INT_CLR, [3] ADDR_INC; others reserved
- DMA_STATE_O  out  8  status: [3:0] FSM code, [4] busy, [5] done, [6] aborted, [7] grant timeout
- DMA_INT_REQ_O  out  1  level interrupt

## Operation
- Each command bit acts on its 0→1 transition; the previous value is registered internally.
- **IDLE**
  - On START, latch all DMA_* inputs and clear status bits [7:5].
  - If LEN = 0, go to DONE without requesting the bus.
  - START while busy is ignored. ABORT in IDLE is ignored. START and ABORT in the same cycle: the start is ignored.
- **Addressing**
  - Framer-side address is the low byte of SRC (dir 0) or DST (dir 1).
  - It increments after each byte if ADDR_INC is set, wrapping 0xFF→0x00; otherwise it is fixed (FIFO register).
  - HPRAM word address is the other operand's [RAM_AW-1:0]. It increments per word and wraps at 2^RAM_AW.
  - Byte k of a word occupies bits [8k+7:8k], little-endian, starting at lane 0.
- **State sequence**
  - REQ: assert BUS_REQ and wait for GNT.
  - ACQ: assert OUTPUT_EN for 1 cycle of turnaround, then start the byte loop.
  - RAMRD (dir 1, lane 0 only): REN pulses; the word is latched on the following cycle.
  - ALE: CSn[sel]=0, BADD_OE=1, BADD_O=address, ALE=1 for ALE_CYC cycles.
  - STB: RDn or WRn low for STB_CYC cycles.
    - Reads: BADD_OE=0 and the byte is sampled on the final STB cycle.
    - Writes: BADD_O carries the data byte.
  - HOLD: strobes high, CSn held for HOLD_CYC cycles; CSn returns to 1 when HOLD ends.
  - RAMWR (dir 0): WEN pulses with the packed word after lane 3 or after the last byte. Unfilled lanes of a partial word are 0.
  - REL: OUTPUT_EN=0, then BUS_REQ=0 on the next cycle.
  - DONE: set done and INT, then return to IDLE.
- **Grant lost mid-transfer:** finish the current byte through HOLD, go to REL, then REQ again and resume. No byte is repeated or skipped.
- **ABORT while busy:** takes effect at the next byte boundary (end of HOLD). A partial word is not written. Then REL, set aborted and INT, return to IDLE.
- **INT_CLR:** clears INT only; the status bits persist until the next START. If a set event and INT_CLR coincide, the set wins.

## Timing
- Reset values: BUS_REQ, OUTPUT_EN, ALE, BADD_OE, BADD_O, HPRAM_* = 0; RDn, WRn = 1; CSn all 1; DMA_STATE_O = 0; INT = 0.
- Reset mid-transfer forces these values immediately (asynchronous) and returns the FSM to IDLE.
- Byte cycle length: ALE_CYC + STB_CYC + HOLD_CYC; plus 1 per word for RAMRD/RAMWR.
- GNT to OUTPUT_EN: 1 cycle; OUTPUT_EN to first ALE: 1 cycle.
- START edge to BUS_REQ: 2 cycles (edge register, then REQ).
- DONE to INT: INT is registered and asserts in the cycle after DONE.

## Configuration
- FALC_DMA_GNT_TIMEOUT_EN defined:
  - A counter runs in REQ; after GNT_TO cycles without a grant, drop BUS_REQ.
  - Set status bit [7] and INT, then return to IDLE.
- FALC_DMA_GNT_TIMEOUT_EN not defined: the engine waits for a grant indefinitely, status bit [7] is constant 0, and GNT_TO is unused.

## Structure
- Package falc_dma_pkg holds the FSM state enum (4-bit codes), the DMA_CMD_I bit indices, the DMA_STATE_O bit positions and the direction constants.
- One sub-module, falc_mux_bus_cycle, sequences a single ALE/STB/HOLD byte cycle: start, done, byte-in and byte-out handshake, timing parameters passed through.

## Test plan
- Framer→HPRAM read, CS 1, src 0x10, dst 0x020, LEN 6, ADDR_INC -> 6 reads at 0x10–0x15 on CSn[1]; WEN at word 0x020 then 0x021 (upper two lanes 0); done=1, INT=1.
- HPRAM→framer write, LEN 4, ADDR_INC clear, HPRAM[0x005]=0x44332211 -> one REN; writes of 0x11, 0x22, 0x33, 0x44 all to the same framer address; WRn low exactly STB_CYC cycles each.
- GNT dropped after byte 2 of 8 -> current byte completes, REQ drops then re-asserts, bytes 3–8 follow with no duplicates.
- ABORT during byte 3 of 8 (dir 0) -> byte 3 completes, no WEN issued, aborted=1, INT=1, BUS_REQ=0.
- With FALC_DMA_GNT_TIMEOUT_EN, GNT tied low -> BUS_REQ drops after 255 cycles, bit[7]=1, INT=1. Without the macro -> BUS_REQ stays high.
- LEN=0 START -> done after 2 cycles, no BUS_REQ. RST_I pulse mid-STB -> all outputs at reset values in the same cycle.
